// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
package display_pkg;

  localparam int DIGITS_DEFAULT = 8;
  localparam logic [DIGITS_DEFAULT-1:0] AN_OFF = '1;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last cycle of each slot.
module tick_gen #(
  parameter int DIV = 4,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt_d,
  output logic          tick
);

  logic [CW-1:0] cnt_q;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans a 32-bit value one nibble per slot onto an 8-digit common-anode display,
// with frame-synchronous value update, leading-zero blanking and a guard interval.
module seven_seg_scanner
  import display_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 8_000,
  parameter int GUARD   = 16,
  parameter int DIGITS  = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic                load,
  input  logic                blank_lz,
  output nibble_t             digit_out,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Bit k set when slot k>0 holds a leading zero (all nibbles at index >= k are 0).
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (v[4*k +: 4] == 4'h0);
      m[k]       = zero_above && (k != 0);
    end
    return m;
  endfunction

  logic [CW-1:0]       cnt_d;
  logic                tick;
  logic                wrap;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  nibble_t             digit_out_q, digit_out_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;
  logic [DIGITS-1:0]   blank_mask;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .cnt_d (cnt_d),
    .tick  (tick)
  );

  // Outputs are computed from next-state values so they change on the slot edge.
  always_comb begin
    wrap      = tick && (idx_q == IW'(DIGITS - 1));
    idx_d     = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);

    pending_d = load ? value_in : pending_q;
    pend_v_d  = pend_v_q | load;
    shadow_d  = shadow_q;
    if (wrap) begin
      pend_v_d = 1'b0;
      if (load)          shadow_d = value_in;
      else if (pend_v_q) shadow_d = pending_q;
    end

    digit_out_d = shadow_d[4*idx_d +: 4];
    blank_mask  = lz_mask(shadow_d);

    an_d = '1;
    if ((cnt_d >= CW'(GUARD)) && !(blank_lz && blank_mask[idx_d]))
      an_d[idx_d] = 1'b0;

    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      digit_out_q  <= '0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      digit_out_q  <= digit_out_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_out  = digit_out_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
